// File: rtl/data_memory_arbiter_if.sv
// Request/response bus between the two requesters and data_memory_arbiter.
//   slave  : arbiter side (takes requests, returns ready and responses)
//   master : requester side (drives requests, samples ready and responses)
// Signals:
//   req_valid[1:0], req_write[1:0]  per-requester valid and write flag
//   req_addr0/1, req_wdata0/1       per-requester word address and write data
//   req_ready[1:0]                  combinational accept, at most one bit high
//   resp_valid[1:0]                 one-cycle response pulse, bit = requester id
//   resp_err, resp_rdata            response payload, meaningful while resp_valid != 0
interface data_memory_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [1:0]            req_valid;
    logic [1:0]            req_write;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic [DATA_WIDTH-1:0] req_wdata0;
    logic [DATA_WIDTH-1:0] req_wdata1;
    logic [1:0]            req_ready;
    logic [1:0]            resp_valid;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport slave (
        input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output req_ready, resp_valid, resp_err, resp_rdata
    );

    modport master (
        output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter and sequencer in front of the single-ported data memory.
// Requester 0 is the CPU datapath, requester 1 the matrix load/store engine.
// One request is accepted at a time, the memory is driven for exactly one cycle,
// and a registered one-cycle response follows.
// Ports:
//   clk_i, rst_i       clock and synchronous active-high reset
//   bus_io             request/response bus (slave side)
//   mem_address_o      memory word address (holds last value outside an access)
//   mem_write_data_o   memory write data (holds last value outside an access)
//   mem_write_enable_o memory write strobe, gated by reset
//   mem_read_enable_o  memory read strobe, gated by reset
//   mem_read_data_i    combinational memory read data
module data_memory_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 512
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    data_memory_arbiter_if.slave  bus_io,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    output logic                  mem_write_enable_o,
    output logic                  mem_read_enable_o,
    input  logic [DATA_WIDTH-1:0] mem_read_data_i
);
    typedef enum logic {StIdle, StAccess} state_e;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  id_q, id_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

    logic [1:0] ready;
    logic       winner;
    logic       in_range;
    logic       access;

    // Full-width unsigned compare: high address bits must not alias into range.
    assign in_range = addr_q < ADDR_WIDTH'(MEM_DEPTH);
    assign access   = (state_q == StAccess);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = '0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        ready        = '0;
        winner       = 1'b0;

        case (state_q)
            StIdle: begin
                // On a tie the requester not served last goes next.
                if (bus_io.req_valid == 2'b11) begin
                    winner = ~last_grant_q;
                end else begin
                    winner = bus_io.req_valid[1];
                end
                if (|bus_io.req_valid) begin
                    ready[winner] = 1'b1;
                    state_d       = StAccess;
                    last_grant_d  = winner;
                    id_d          = winner;
                    wr_d          = bus_io.req_write[winner];
                    addr_d        = winner ? bus_io.req_addr1  : bus_io.req_addr0;
                    wdata_d       = winner ? bus_io.req_wdata1 : bus_io.req_wdata0;
                end
            end
            StAccess: begin
                state_d              = StIdle;
                resp_valid_d[id_q]   = 1'b1;
                resp_err_d           = ~in_range;
                resp_rdata_d         = (!wr_q && in_range) ? mem_read_data_i : '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus_io.req_ready  = ready;
    assign bus_io.resp_valid = resp_valid_q;
    assign bus_io.resp_err   = resp_err_q;
    assign bus_io.resp_rdata = resp_rdata_q;

    // Latched request registers drive the memory directly, so address and data
    // naturally hold between accesses.
    assign mem_address_o      = addr_q;
    assign mem_write_data_o   = wdata_q;
    // Reset gates the strobes so an access interrupted by reset has no side effect.
    assign mem_write_enable_o = access & wr_q & in_range & ~rst_i;
    assign mem_read_enable_o  = access & ~wr_q & in_range & ~rst_i;
endmodule
